// File: rtl/enable_sequencer.sv
// enable_sequencer: raises N_STAGES enables one at a time in index order and lowers them in reverse.
// Optional macro SEQ_TIMEOUT_EN adds a per-stage ready timeout that raises fault.
module enable_sequencer #(
    parameter int N_STAGES  = 4,
    parameter int BIT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable_req,
    input  logic [BIT_WIDTH-1:0] step_delay,
    input  logic [BIT_WIDTH-1:0] timeout,
    input  logic [N_STAGES-1:0]  stage_ready,
    output logic [N_STAGES-1:0]  stage_en,
    output logic                 all_up,
    output logic                 busy,
    output logic                 fault
);
    localparam int               IDX_W = $clog2(N_STAGES);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_STAGES - 1);

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        WAIT_READY,
        UP,
        DOWN
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [BIT_WIDTH-1:0] cnt_q, cnt_d;
    logic [N_STAGES-1:0]  en_q, en_d;
    logic [N_STAGES-1:0]  stage_en_q;
    logic                 all_up_q, busy_q, fault_q, fault_d;
    logic                 ready_lost;

`ifdef SEQ_TIMEOUT_EN
    logic [BIT_WIDTH-1:0] tmo_q, tmo_d;
    logic                 tmo_arm_q, tmo_arm_d;
`else
    logic                 unused_timeout;
    assign unused_timeout = ^timeout;
`endif

    assign ready_lost = ((en_q & ~stage_ready) != '0);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        en_d    = en_q;
        fault_d = fault_q;
`ifdef SEQ_TIMEOUT_EN
        tmo_d     = tmo_q;
        tmo_arm_d = tmo_arm_q;
`endif
        case (state_q)
            IDLE: begin
                if (!enable_req) begin
                    fault_d = 1'b0;
                end else if (!fault_q) begin
                    idx_d   = '0;
                    cnt_d   = step_delay;
                    state_d = DELAY;
                end
            end
            DELAY: begin
                if (!enable_req) begin
                    // The stage being delayed is not enabled yet, so teardown starts one below it.
                    if (idx_q != '0) idx_d = idx_q - IDX_W'(1);
                    cnt_d   = step_delay;
                    state_d = DOWN;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - BIT_WIDTH'(1);
                end else begin
                    en_d[idx_q] = 1'b1;
                    state_d     = WAIT_READY;
`ifdef SEQ_TIMEOUT_EN
                    tmo_d     = timeout;
                    tmo_arm_d = (timeout != '0);
`endif
                end
            end
            WAIT_READY: begin
                if (!enable_req) begin
                    cnt_d   = step_delay;
                    state_d = DOWN;
                end else if (stage_ready[idx_q]) begin
                    if (idx_q == LAST) begin
                        state_d = UP;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        cnt_d   = step_delay;
                        state_d = DELAY;
                    end
`ifdef SEQ_TIMEOUT_EN
                end else if (tmo_arm_q && (tmo_q == '0)) begin
                    fault_d = 1'b1;
                    cnt_d   = step_delay;
                    state_d = DOWN;
                end else if (tmo_q != '0) begin
                    tmo_d = tmo_q - BIT_WIDTH'(1);
`endif
                end
            end
            UP: begin
                if (!enable_req || ready_lost) begin
                    if (ready_lost) fault_d = 1'b1;
                    idx_d   = LAST;
                    cnt_d   = step_delay;
                    state_d = DOWN;
                end
            end
            DOWN: begin
                if (en_q == '0) begin
                    idx_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - BIT_WIDTH'(1);
                end else begin
                    en_d[idx_q] = 1'b0;
                    if (idx_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                        cnt_d = step_delay;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // stage_en is a second register behind en_q, so a step decision reaches the pins one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            en_q       <= '0;
            stage_en_q <= '0;
            all_up_q   <= 1'b0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            en_q       <= en_d;
            stage_en_q <= en_q;
            all_up_q   <= (state_d == UP);
            busy_q     <= (state_d == DELAY) || (state_d == WAIT_READY) || (state_d == DOWN);
            fault_q    <= fault_d;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q     <= '0;
            tmo_arm_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            tmo_arm_q <= tmo_arm_d;
        end
    end
`endif

    assign stage_en = stage_en_q;
    assign all_up   = all_up_q;
    assign busy     = busy_q;
    assign fault    = fault_q;

endmodule

// File: tb/tb_enable_sequencer.sv
// Bench for enable_sequencer: directed and randomized power-up/down episodes, each checked every cycle
// against an event timeline computed arithmetically from the sequencing rules.
module tb_enable_sequencer;
    localparam int N     = 4;
    localparam int BW    = 16;
    localparam int STALL = 100000;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable_req;
    logic [BW-1:0] step_delay;
    logic [BW-1:0] timeout;
    logic [N-1:0]  stage_ready;
    logic [N-1:0]  stage_en;
    logic          all_up;
    logic          busy;
    logic          fault;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int lat [N];

    enable_sequencer #(.N_STAGES(N), .BIT_WIDTH(BW)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable_req  (enable_req),
        .step_delay  (step_delay),
        .timeout     (timeout),
        .stage_ready (stage_ready),
        .stage_en    (stage_en),
        .all_up      (all_up),
        .busy        (busy),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [N-1:0] e_en, input logic e_up,
                           input logic e_busy, input logic e_fault);
        chk({tag, ".stage_en"}, 32'(stage_en), 32'(e_en));
        chk({tag, ".all_up"},   32'(all_up),   32'(e_up));
        chk({tag, ".busy"},     32'(busy),     32'(e_busy));
        chk({tag, ".fault"},    32'(fault),    32'(e_fault));
    endtask

    // mode 0: enable_req drops at edge d; mode 1: stage_ready[loss_k] drops in UP at edge d;
    // mode 2: first stalled stage times out, d = its enable edge + tmo.
    task automatic episode(input int sd, input int sdd, input int mode, input bit from_up,
                           input int d_rel, input int loss_k, input int tmo, input int rst_after);
        int a, d, h, d_end, s_up, c_end;
        int e [N];
        int s [N];
        int dn [N];
        logic [N-1:0] ee;
        step_delay = BW'(sd);
        timeout    = BW'(tmo);
        enable_req = 1'b1;
        a = cyc + 1;
        for (int k = 0; k < N; k++) begin
            e[k] = (k == 0) ? a + sd + 2 : s[k-1] + sd + 2;
            s[k] = e[k] + lat[k];
        end
        if (mode == 2) begin
            d = -1;
            for (int k = 0; k < N; k++) if (lat[k] >= STALL && d < 0) d = e[k] + tmo;
        end else begin
            d = from_up ? s[N-1] + d_rel : a + d_rel;
        end
        h = -1;
        for (int k = 0; k < N; k++) if (e[k] - 1 < d) h = k;
        for (int k = 0; k < N; k++) dn[k] = d + (h - k + 1) * (sdd + 1) + 1;
        d_end = (h < 0) ? d + 1 : d + (h + 1) * (sdd + 1);
        s_up  = (s[N-1] < d) ? s[N-1] : d;
        c_end = d_end + 3;
        while (cyc < c_end) begin
            step();
            ee = '0;
            for (int k = 0; k < N; k++) if (k <= h && cyc >= e[k] && cyc < dn[k]) ee[k] = 1'b1;
            chk_all("episode", ee, (s[N-1] < d) && cyc >= s[N-1] && cyc < d,
                    (cyc >= a && cyc < s_up) || (cyc >= d && cyc < d_end),
                    (mode != 0) && cyc >= d);
            if (rst_after >= 0 && cyc == d + rst_after) begin
                #2 reset = 1'b1;
                #1 chk_all("async_reset", '0, 1'b0, 1'b0, 1'b0);
                enable_req  = 1'b0;
                stage_ready = '0;
                step();
                step();
                reset = 1'b0;
                return;
            end
            for (int k = 0; k < N; k++) if (cyc == s[k] - 1) stage_ready[k] = 1'b1;
            if (cyc == d - 1) begin
                step_delay = BW'(sdd);
                if (mode == 0) enable_req = 1'b0;
                if (mode == 1) stage_ready[loss_k] = 1'b0;
            end
        end
        if (mode != 0) begin
            repeat (4) begin
                step();
                chk_all("fault_hold", '0, 1'b0, 1'b0, 1'b1);
            end
            enable_req = 1'b0;
            step();
            chk_all("fault_clear", '0, 1'b0, 1'b0, 1'b0);
        end
        stage_ready = '0;
        step();
    endtask

    initial begin
        reset       = 1'b1;
        enable_req  = 1'b0;
        step_delay  = '0;
        timeout     = '0;
        stage_ready = '0;
        step();
        chk_all("reset", '0, 1'b0, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        step();
        chk_all("idle", '0, 1'b0, 1'b0, 1'b0);

        // Full ramp with delay 3, teardown from UP with delay 2.
        for (int k = 0; k < N; k++) lat[k] = 1;
        episode(3, 2, 0, 1'b1, 4, 0, 0, -1);
        // Ready loss on stage 1 while UP, request held high.
        episode(2, 2, 1, 1'b1, 3, 1, 0, -1);
        // Request drops on the edge where stage 2's delay expires.
        episode(3, 3, 0, 1'b0, 16, 0, 0, -1);
        // Request drops together with stage 1 ready.
        episode(3, 3, 0, 1'b0, 12, 0, 0, -1);
        // Request drops during stage 0's delay: nothing enabled yet.
        episode(2, 2, 0, 1'b0, 2, 0, 0, -1);
        // Zero delay, ready loss on stage 2, asynchronous reset mid-teardown.
        episode(0, 0, 1, 1'b1, 2, 2, 0, 1);
        step();
        chk_all("post_reset", '0, 1'b0, 1'b0, 1'b0);

        // Stage 2 never becomes ready.
        lat[0] = 1; lat[1] = 1; lat[2] = STALL; lat[3] = 1;
`ifdef SEQ_TIMEOUT_EN
        episode(1, 1, 2, 1'b0, 0, 0, 10, -1);
`else
        episode(1, 1, 0, 1'b0, 51, 0, 10, -1);
`endif

        for (int r = 0; r < 12; r++) begin
            int sd, sdd, mode, d_rel, loss_k;
            bit from_up;
            for (int k = 0; k < N; k++) lat[k] = int'($urandom_range(1, 3));
            sd      = int'($urandom_range(0, 4));
            sdd     = int'($urandom_range(0, 4));
            mode    = int'($urandom_range(0, 1));
            from_up = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            d_rel   = from_up ? int'($urandom_range(1, 6)) : int'($urandom_range(1, 30));
            loss_k  = int'($urandom_range(0, N - 1));
            episode(sd, sdd, mode, from_up, d_rel, loss_k, 0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
